// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key tracker.
// Prefix and key scancodes, the queued event layout and the parser state encoding.
package ps2_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_UP   = 8'h75;
    localparam logic [7:0] SC_DOWN = 8'h72;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_S    = 8'h1B;

    // One key event as stored in the FIFO (10 bits: code, ext, brk)
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    // Keyboard status/response bytes that never form part of a key sequence
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hFE) || (b == 8'hEE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with registered head, empty and full outputs.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Handshake: an entry is presented while empty=0; it leaves when pop=1 in that
// cycle. A push while full is accepted only if a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic         do_push, do_pop;

    // Accept/advance decisions and next pointer values
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
        rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};
    end

    // Storage array write
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers plus registered head/status derived from the next pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            empty  <= (wr_nxt == rd_nxt);
            full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                      (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            // The entry being written becomes the head when it lands at the read pointer
            if (do_push && (wr_ptr == rd_nxt)) dout <= din;
            else                               dout <= mem[rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scancode parser: turns E0/F0-prefixed byte sequences into make/break
// events, queues them, and tracks held flags for both paddles.
// Build option: TYPEMATIC_FILTER_EN drops repeated makes of already-held keys
// from the event queue (held flags behave the same either way).
// Event handshake: evt_* is valid while evt_vld=1; the head is consumed on a
// clock where evt_vld=1 and evt_rdy=1.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       evt_vld,
    input  logic       evt_rdy,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       ovf
);

    ps2_state_t state, state_nxt;
    ps2_evt_t   emit_evt, head;
    logic       emit, push, full, empty, repeat_make, drop;
    logic       hit_p1_up, hit_p1_down, hit_p2_up, hit_p2_down;

    // Parser state register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Parser next state and event emission; only a byte strobe moves the parser
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_evt  = '{code: byte_in, ext: 1'b0, brk: 1'b0};
        if (byte_vld) begin
            if (is_ignored(byte_in)) begin
                state_nxt = ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if      (byte_in == SC_EXT) state_nxt = ST_EXT;
                        else if (byte_in == SC_BRK) state_nxt = ST_BRK;
                        else                        emit      = 1'b1;
                    end
                    ST_EXT: begin
                        if      (byte_in == SC_BRK) state_nxt = ST_EXT_BRK;
                        else if (byte_in == SC_EXT) state_nxt = ST_EXT;
                        else begin
                            emit         = 1'b1;
                            emit_evt.ext = 1'b1;
                            state_nxt    = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        state_nxt = ST_IDLE;
                        if (byte_in != SC_EXT && byte_in != SC_BRK) begin
                            emit         = 1'b1;
                            emit_evt.brk = 1'b1;
                        end
                    end
                    ST_EXT_BRK: begin
                        state_nxt = ST_IDLE;
                        if (byte_in != SC_EXT && byte_in != SC_BRK) begin
                            emit         = 1'b1;
                            emit_evt.ext = 1'b1;
                            emit_evt.brk = 1'b1;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Which tracked key (if any) the emitted event refers to
    always_comb begin
        hit_p1_up   = emit &  emit_evt.ext & (emit_evt.code == SC_UP);
        hit_p1_down = emit &  emit_evt.ext & (emit_evt.code == SC_DOWN);
        hit_p2_up   = emit & ~emit_evt.ext & (emit_evt.code == SC_W);
        hit_p2_down = emit & ~emit_evt.ext & (emit_evt.code == SC_S);
    end

`ifdef TYPEMATIC_FILTER_EN
    // Autorepeat makes of a key already held are not queued
    assign repeat_make = ~emit_evt.brk & ((hit_p1_up & p1_up) | (hit_p1_down & p1_down) |
                                          (hit_p2_up & p2_up) | (hit_p2_down & p2_down));
`else
    assign repeat_make = 1'b0;
`endif

    assign push = emit & ~repeat_make;
    assign drop = push & full & ~(evt_rdy & evt_vld);

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW),
        .W     (10)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (evt_rdy),
        .din   (emit_evt),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt_code = head.code;
    assign evt_ext  = head.ext;
    assign evt_brk  = head.brk;
    assign evt_vld  = ~empty;

    // Held flags: make sets and clears the opposite direction, break clears
    always_ff @(posedge clock) begin
        if (reset) begin
            p1_up   <= 1'b0;
            p1_down <= 1'b0;
            p2_up   <= 1'b0;
            p2_down <= 1'b0;
        end else begin
            if (hit_p1_up) begin
                p1_up <= ~emit_evt.brk;
                if (!emit_evt.brk) p1_down <= 1'b0;
            end
            if (hit_p1_down) begin
                p1_down <= ~emit_evt.brk;
                if (!emit_evt.brk) p1_up <= 1'b0;
            end
            if (hit_p2_up) begin
                p2_up <= ~emit_evt.brk;
                if (!emit_evt.brk) p2_down <= 1'b0;
            end
            if (hit_p2_down) begin
                p2_down <= ~emit_evt.brk;
                if (!emit_evt.brk) p2_up <= 1'b0;
            end
        end
    end

    // Sticky overflow: set when an event is lost to a full queue
    always_ff @(posedge clock) begin
        if (reset)     ovf <= 1'b0;
        else if (drop) ovf <= 1'b1;
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with hand-computed expected events.
// Honours TYPEMATIC_FILTER_EN for the autorepeat expectations.
module tb_ps2_key_tracker;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_vld = 1'b0;
    logic       evt_rdy = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext, evt_brk, evt_vld;
    logic       p1_up, p1_down, p2_up, p2_down, ovf;

    int n_checks = 0;
    int n_fail   = 0;
    logic both_seen = 1'b0;
    logic [9:0] exp_q[$];

    ps2_key_tracker #(.FIFO_DEPTH(4), .AW(2)) dut (
        .clock    (clock),
        .reset    (reset),
        .byte_in  (byte_in),
        .byte_vld (byte_vld),
        .evt_code (evt_code),
        .evt_ext  (evt_ext),
        .evt_brk  (evt_brk),
        .evt_vld  (evt_vld),
        .evt_rdy  (evt_rdy),
        .p1_up    (p1_up),
        .p1_down  (p1_down),
        .p2_up    (p2_up),
        .p2_down  (p2_down),
        .ovf      (ovf)
    );

    // 50 MHz clock
    always #10 clock = ~clock;

    // Watch for both directions of one paddle held at once
    always @(negedge clock) begin
        if (!reset && ((p1_up && p1_down) || (p2_up && p2_down))) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] head_word();
        return {22'd0, evt_code, evt_ext, evt_brk};
    endfunction

    function automatic logic [31:0] ev(input logic [7:0] c, input logic e, input logic b);
        return {22'd0, c, e, b};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One strobe, then idle so strobes stay at least 8 clocks apart
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        byte_in  = b;
        byte_vld = 1'b1;
        @(negedge clock);
        byte_vld = 1'b0;
        repeat (7) @(negedge clock);
    endtask

    task automatic pop_one();
        @(negedge clock);
        evt_rdy = 1'b1;
        @(negedge clock);
        evt_rdy = 1'b0;
    endtask

    // Compare the head against the expected queue until it drains
    task automatic drain_expect(input string tag);
        logic [9:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_vld"}, 32'(evt_vld), 32'd1);
            check({tag, "_head"}, head_word(), {22'd0, e});
            pop_one();
        end
        check({tag, "_empty"}, 32'(evt_vld), 32'd0);
    endtask

    task automatic count_events(output int cnt);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (evt_vld) begin
                cnt++;
                pop_one();
            end
        end
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check("rst_vld", 32'(evt_vld), 32'd0);
        check("rst_head", head_word(), 32'd0);
        check("rst_flags", 32'({p1_up, p1_down, p2_up, p2_down}), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // W make: event one clock after the strobe
        @(negedge clock);
        byte_in = 8'h1D; byte_vld = 1'b1;
        check("w_pre_vld", 32'(evt_vld), 32'd0);
        @(negedge clock);
        byte_vld = 1'b0;
        check("w_lat_vld", 32'(evt_vld), 32'd1);
        check("w_make", head_word(), ev(8'h1D, 1'b0, 1'b0));
        check("w_p2_up", 32'(p2_up), 32'd1);
        repeat (7) @(negedge clock);
        pop_one();
        check("w_popped", 32'(evt_vld), 32'd0);

        // W break
        send_byte(8'hF0);
        check("f0_no_evt", 32'(evt_vld), 32'd0);
        send_byte(8'h1D);
        check("w_break", head_word(), ev(8'h1D, 1'b0, 1'b1));
        check("w_p2_up_clr", 32'(p2_up), 32'd0);
        pop_one();

        // Arrow up then arrow down
        send_byte(8'hE0);
        send_byte(8'h75);
        check("up_p1_up", 32'(p1_up), 32'd1);
        send_byte(8'hE0);
        send_byte(8'h72);
        check("dn_p1_up", 32'(p1_up), 32'd0);
        check("dn_p1_down", 32'(p1_down), 32'd1);
        exp_q.push_back({8'h75, 1'b1, 1'b0});
        exp_q.push_back({8'h72, 1'b1, 1'b0});
        drain_expect("arrows");

        // Pop while empty has no effect
        pop_one();
        check("pop_empty", 32'(evt_vld), 32'd0);

        // Overflow: five makes into four entries, then push+pop at full
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'h17);
        send_byte(8'h18);
        check("full_no_ovf", 32'(ovf), 32'd0);
        send_byte(8'h19);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_head", head_word(), ev(8'h15, 1'b0, 1'b0));
        @(negedge clock);
        byte_in = 8'h1A; byte_vld = 1'b1; evt_rdy = 1'b1;
        @(negedge clock);
        byte_vld = 1'b0; evt_rdy = 1'b0;
        repeat (7) @(negedge clock);
        check("ovf_sticky", 32'(ovf), 32'd1);
        exp_q.push_back({8'h16, 1'b0, 1'b0});
        exp_q.push_back({8'h17, 1'b0, 1'b0});
        exp_q.push_back({8'h18, 1'b0, 1'b0});
        exp_q.push_back({8'h1A, 1'b0, 1'b0});
        drain_expect("full_pp");

        // Reset mid-sequence discards the prefix
        send_byte(8'hE0);
        send_byte(8'hF0);
        do_reset();
        check("rst2_ovf", 32'(ovf), 32'd0);
        send_byte(8'h72);
        check("midrst_evt", head_word(), ev(8'h72, 1'b0, 1'b0));
        check("midrst_p1_down", 32'(p1_down), 32'd0);
        pop_one();

        // Autorepeat of W
        send_byte(8'h1D);
        send_byte(8'h1D);
        send_byte(8'h1D);
        check("rep_p2_up", 32'(p2_up), 32'd1);
        count_events(cnt);
`ifdef TYPEMATIC_FILTER_EN
        check("rep_count", 32'(cnt), 32'd1);
`else
        check("rep_count", 32'(cnt), 32'd3);
`endif
        send_byte(8'hF0);
        send_byte(8'h1D);
        check("rep_release", 32'(p2_up), 32'd0);
        pop_one();

        // Malformed F0 E0 and ignored AA produce nothing
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'hAA);
        check("malformed_none", 32'(evt_vld), 32'd0);
        send_byte(8'h75);
        check("after_malformed", head_word(), ev(8'h75, 1'b0, 1'b0));
        check("plain75_p1_up", 32'(p1_up), 32'd0);
        pop_one();

        // Ignored byte between prefix and code drops the prefix
        send_byte(8'hE0);
        send_byte(8'hFA);
        send_byte(8'h75);
        check("ign_prefix", head_word(), ev(8'h75, 1'b0, 1'b0));
        pop_one();

        // Repeated E0 stays extended; extended break clears the flag
        send_byte(8'hE0);
        send_byte(8'hE0);
        send_byte(8'h75);
        check("e0e0_flag", 32'(p1_up), 32'd1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("extbrk_flag", 32'(p1_up), 32'd0);
        exp_q.push_back({8'h75, 1'b1, 1'b0});
        exp_q.push_back({8'h75, 1'b1, 1'b1});
        drain_expect("ext_seq");

        check("never_both", 32'(both_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
